// File: rtl/uart_tx_scheduler_if.sv
// Byte-request bus between NUM_REQ on-chip byte sources and the UART scheduler.
// Sources drive valid/data/last; the scheduler answers with a one-hot ready.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, output req_last, input req_ready);
    modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: arbitrates NUM_REQ byte sources onto one
// 8N1 line, locking the line to a source until its packet's last byte.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_scheduler_if.slave rq,
    output logic               uart_tx,
    output logic               busy,
    output logic               lock_active,
    output logic [2:0]         lock_id
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] lock_idx_q, lock_idx_d;
    logic          lock_active_q, lock_active_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          win_vld, gnt_vld, baud_last;
    logic [PW-1:0] win_idx, gnt_idx, nxt_ptr;
    int            idx;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_vld && rq.req_valid[idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    // Grant only in IDLE; a held lock masks everyone but the holder.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = win_idx;
        if (state_q == IDLE) begin
            if (lock_active_q) begin
                gnt_vld = rq.req_valid[lock_idx_q];
                gnt_idx = lock_idx_q;
            end else begin
                gnt_vld = win_vld;
            end
        end
    end

    assign rq.req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign nxt_ptr      = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    assign baud_last    = (baud_q == BW'(CLKS_PER_BIT - 1));

    // Next-state logic: acceptance, lock timeout and the 8N1 frame sequencing.
    // tx_d follows the next state so the line is registered and glitch-free.
    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        data_d        = data_q;
        tx_d          = tx_q;
        ptr_d         = ptr_q;
        lock_idx_d    = lock_idx_q;
        lock_active_d = lock_active_q;
        tmo_d         = tmo_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (gnt_vld) begin
                    data_d        = rq.req_data[{gnt_idx, 3'b000} +: 8];
                    state_d       = START;
                    baud_d        = '0;
                    tx_d          = 1'b0;
                    ptr_d         = nxt_ptr;
                    lock_idx_d    = gnt_idx;
                    lock_active_d = ~rq.req_last[gnt_idx];
                    tmo_d         = '0;
                end else if (lock_active_q) begin
                    // Counter value reaching the limit releases the lock on the following edge.
                    if (tmo_q == TW'(LOCK_TIMEOUT)) begin
                        lock_active_d = 1'b0;
                        tmo_d         = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any frame in flight and idles the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            baud_q        <= '0;
            bit_q         <= '0;
            data_q        <= '0;
            tx_q          <= 1'b1;
            ptr_q         <= '0;
            lock_idx_q    <= '0;
            lock_active_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            data_q        <= data_d;
            tx_q          <= tx_d;
            ptr_q         <= ptr_d;
            lock_idx_q    <= lock_idx_d;
            lock_active_q <= lock_active_d;
            tmo_q         <= tmo_d;
        end
    end

    assign uart_tx     = tx_q;
    assign busy        = (state_q != IDLE);
    assign lock_active = lock_active_q;
    assign lock_id     = 3'(lock_idx_q);

endmodule
